// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
// Multi-channel programmable clock divider. Each of NCH channels divides clk_in
// by an integer ratio, odd or even. Each channel produces a flop-driven divided
// clock and a one-cycle tick in the last input cycle of every output period.
// A new ratio loaded while a channel runs is held in a shadow register. It
// becomes active only at the next period wrap, so clk_out never glitches.
//
// Optional feature (compile-time macro): CLK_DIV_SYNC_EN
//   When defined, a pulse on `sync` restarts every enabled channel at the
//   start of its high phase, re-aligning all channels. When undefined, the
//   sync port is present but ignored, and no sync logic is built.
//
// Parameters
//   NCH        number of independent channels
//   WIDTH      ratio/counter width (max period 2^WIDTH-1 cycles)
//   DEF_RATIO  active ratio of every channel after reset
//
// Ports
//   clk_in     source clock, all logic on its rising edge
//   rst        synchronous active-high reset
//   enable     per-channel run enable
//   load       per-channel ratio load strobe (one cycle)
//   div_ratio  requested ratios, channel c at [c*WIDTH +: WIDTH]
//   sync       global phase-align strobe (CLK_DIV_SYNC_EN only)
//   clk_out    divided clocks (registered)
//   tick       one-cycle pulse in the final cycle of each period (registered)
//   pending    a loaded ratio waits for the next period boundary (registered)
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int NCH       = 4,
  parameter int WIDTH     = 8,
  parameter int DEF_RATIO = 2
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic [NCH-1:0]       enable,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] div_ratio,
  input  logic                 sync,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       pending
);

  localparam logic [WIDTH-1:0] ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DEF_R = WIDTH'(DEF_RATIO);

  // A ratio of 0 would give an empty period; it runs as divide-by-1 instead.
  function automatic logic [WIDTH-1:0] period_of(input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] p;
    if (r == ZERO) begin
      p = ONE;
    end else begin
      p = r;
    end
    return p;
  endfunction

  // Length of the high phase, ceil(P/2), kept one bit wider so P=2^WIDTH-1
  // cannot overflow the +1.
  function automatic logic [WIDTH:0] half_of(input logic [WIDTH-1:0] p);
    return ({1'b0, p} + {{WIDTH{1'b0}}, 1'b1}) >> 1'b1;
  endfunction

`ifndef CLK_DIV_SYNC_EN
  // sync has no function in this build; tie it off so it is visibly unused.
  logic sync_unused_s;
  assign sync_unused_s = sync;
`endif

  for (genvar c = 0; c < NCH; c++) begin : ch_g

    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] shadow_r;
    logic             clk_r;
    logic             tick_r;
    logic             pend_r;

    logic [WIDTH-1:0] req_s;
    logic [WIDTH-1:0] p_old_s;
    logic             wrap_s;

    logic [WIDTH-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] act_nxt_s;
    logic [WIDTH-1:0] shd_nxt_s;
    logic [WIDTH-1:0] p_new_s;
    logic [WIDTH:0]   half_s;
    logic             clk_nxt_s;
    logic             tick_nxt_s;
    logic             pend_nxt_s;

    assign req_s   = div_ratio[c*WIDTH +: WIDTH];
    assign p_old_s = period_of(active_r);
    // The wrap is judged against the ratio in force for the current period.
    assign wrap_s  = (cnt_r == (p_old_s - ONE));

    // Next-state decode for one channel: disabled hold/load, optional sync,
    // then normal counting with ratio hand-over at the wrap.
    always_comb begin
      cnt_nxt_s  = cnt_r;
      act_nxt_s  = active_r;
      shd_nxt_s  = shadow_r;
      pend_nxt_s = pend_r;
      clk_nxt_s  = clk_r;
      tick_nxt_s = 1'b0;
      p_new_s    = p_old_s;
      half_s     = half_of(p_old_s);

      if (!enable[c]) begin
        // A stopped channel has no period to protect, so a load takes
        // effect at once and restarts it in the low state.
        if (load[c]) begin
          act_nxt_s  = req_s;
          shd_nxt_s  = req_s;
          cnt_nxt_s  = ZERO;
          clk_nxt_s  = 1'b0;
          pend_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s  = cnt_r;
          clk_nxt_s  = clk_r;
        end
      end
`ifdef CLK_DIV_SYNC_EN
      else if (sync) begin
        // Restart at count 0 (start of high phase) with the newest ratio
        // already committed, so all channels re-align on a clean edge.
        if (load[c]) begin
          act_nxt_s = req_s;
          shd_nxt_s = req_s;
        end else if (pend_r) begin
          act_nxt_s = shadow_r;
        end else begin
          act_nxt_s = active_r;
        end
        p_new_s    = period_of(act_nxt_s);
        pend_nxt_s = 1'b0;
        cnt_nxt_s  = ZERO;
        clk_nxt_s  = 1'b1;
        tick_nxt_s = (p_new_s == ONE);
      end
`endif
      else begin
        if (load[c]) begin
          shd_nxt_s = req_s;
        end else begin
          shd_nxt_s = shadow_r;
        end

        if (wrap_s) begin
          // Period boundary: commit a same-cycle load, else a waiting one.
          if (load[c]) begin
            act_nxt_s = req_s;
          end else if (pend_r) begin
            act_nxt_s = shadow_r;
          end else begin
            act_nxt_s = active_r;
          end
          pend_nxt_s = 1'b0;
          cnt_nxt_s  = ZERO;
        end else begin
          if (load[c]) begin
            pend_nxt_s = 1'b1;
          end else begin
            pend_nxt_s = pend_r;
          end
          act_nxt_s = active_r;
          cnt_nxt_s = cnt_r + ONE;
        end

        // Decode outputs with the period that the new count belongs to.
        p_new_s    = period_of(act_nxt_s);
        half_s     = half_of(p_new_s);
        clk_nxt_s  = ({1'b0, cnt_nxt_s} < half_s);
        tick_nxt_s = (cnt_nxt_s == (p_new_s - ONE));
      end
    end

    // Channel state and registered outputs, with synchronous reset.
    always_ff @(posedge clk_in) begin
      if (rst) begin
        cnt_r    <= ZERO;
        active_r <= DEF_R;
        shadow_r <= DEF_R;
        clk_r    <= 1'b0;
        tick_r   <= 1'b0;
        pend_r   <= 1'b0;
      end else begin
        cnt_r    <= cnt_nxt_s;
        active_r <= act_nxt_s;
        shadow_r <= shd_nxt_s;
        clk_r    <= clk_nxt_s;
        tick_r   <= tick_nxt_s;
        pend_r   <= pend_nxt_s;
      end
    end

    assign clk_out[c] = clk_r;
    assign tick[c]    = tick_r;
    assign pending[c] = pend_r;

  end : ch_g

endmodule

// File: tb/tb_clk_div_multi.sv
// -----------------------------------------------------------------------------
// tb_clk_div_multi
// Directed test of clk_div_multi (NCH=4, WIDTH=8, DEF_RATIO=2). Each stimulus
// step pushes its hand-computed clk_out/tick/pending vectors, with a care
// mask, into a queue on the clock edge. A monitor pops one entry on every
// falling edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_clk_div_multi;

  logic        clk_in = 1'b0;
  logic        rst;
  logic [3:0]  enable;
  logic [3:0]  load;
  logic [31:0] div_ratio;
  logic        sync;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  pending;

  clk_div_multi #(
    .NCH       (4),
    .WIDTH     (8),
    .DEF_RATIO (2)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .enable    (enable),
    .load      (load),
    .div_ratio (div_ratio),
    .sync      (sync),
    .clk_out   (clk_out),
    .tick      (tick),
    .pending   (pending)
  );

  // Free-running source clock.
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] care;
    logic [3:0] e_clk;
    logic [3:0] e_tick;
    logic [3:0] e_pend;
    int         step;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  task automatic check(input string nm, input int step,
                       input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", nm, step, got, want);
    end
  endtask

  // One clock edge: inputs were set by the caller; queue what that edge must
  // produce (nothing when care is 0), then return on the falling edge.
  task automatic cyc(input logic [3:0] care, input logic [3:0] e_clk,
                     input logic [3:0] e_tick, input logic [3:0] e_pend);
    exp_t e;
    @(posedge clk_in);
    step_no++;
    if (care != 4'b0000) begin
      e.care   = care;
      e.e_clk  = e_clk;
      e.e_tick = e_tick;
      e.e_pend = e_pend;
      e.step   = step_no;
      exp_q.push_back(e);
    end
    @(negedge clk_in);
  endtask

  task automatic set_ratio(input int c, input int r);
    div_ratio[c*8 +: 8] = 8'(r);
  endtask

  // Monitor: compare the outputs against the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk_in);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("clk_out", e.step, clk_out & e.care, e.e_clk  & e.care);
        check("tick",    e.step, tick    & e.care, e.e_tick & e.care);
        check("pending", e.step, pending & e.care, e.e_pend & e.care);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected normal end");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst = 1'b1; enable = 4'h0; load = 4'h0; div_ratio = 32'h0; sync = 1'b0;

    // Reset state.
    cyc(4'hF, 4'h0, 4'h0, 4'h0);
    cyc(4'hF, 4'h0, 4'h0, 4'h0);

    // Default ratio 2 on all channels.
    rst = 1'b0; enable = 4'hF;
    cyc(4'hF, 4'h0, 4'hF, 4'h0);
    cyc(4'hF, 4'hF, 4'h0, 4'h0);
    cyc(4'hF, 4'h0, 4'hF, 4'h0);
    cyc(4'hF, 4'hF, 4'h0, 4'h0);

    // Ratio 3 loaded into stopped ch0; ch1-3 keep running at ratio 2.
    enable = 4'b1110; load = 4'b0001; set_ratio(0, 3);
    cyc(4'hF, 4'b0000, 4'b1110, 4'h0);
    load = 4'h0; enable = 4'hF;
    cyc(4'hF, 4'b1111, 4'b0000, 4'h0);
    cyc(4'hF, 4'b0000, 4'b1111, 4'h0);
    cyc(4'hF, 4'b1111, 4'b0000, 4'h0);
    cyc(4'hF, 4'b0001, 4'b1110, 4'h0);
    cyc(4'hF, 4'b1110, 4'b0001, 4'h0);
    cyc(4'hF, 4'b0001, 4'b1110, 4'h0);

    // Ratio 4 on ch0, then load 7 at cnt=1: applies at the wrap.
    enable = 4'h0; load = 4'b0001; set_ratio(0, 4);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    load = 4'h0; enable = 4'h1;
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    load = 4'h1; set_ratio(0, 7);
    cyc(4'h1, 4'h0, 4'h0, 4'h1);
    load = 4'h0;
    cyc(4'h1, 4'h0, 4'h1, 4'h1);
    for (int i = 0; i < 4; i++) cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h1, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);

    // Load while pending: 5 is overwritten by 3.
    load = 4'h1; set_ratio(0, 5);
    cyc(4'h1, 4'h1, 4'h0, 4'h1);
    set_ratio(0, 3);
    cyc(4'h1, 4'h1, 4'h0, 4'h1);
    load = 4'h0;
    cyc(4'h1, 4'h1, 4'h0, 4'h1);
    cyc(4'h1, 4'h0, 4'h0, 4'h1);
    cyc(4'h1, 4'h0, 4'h0, 4'h1);
    cyc(4'h1, 4'h0, 4'h1, 4'h1);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h1, 4'h0);
    // Load on the wrap cycle: ratio 2 applies immediately, no pending.
    load = 4'h1; set_ratio(0, 2);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    load = 4'h0;
    cyc(4'h1, 4'h0, 4'h1, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);

    // Ratio 0 and ratio 1: clk_out stuck high, tick every enabled cycle.
    enable = 4'h0; load = 4'h1; set_ratio(0, 0);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    load = 4'h0; enable = 4'h1;
    for (int i = 0; i < 3; i++) cyc(4'h1, 4'h1, 4'h1, 4'h0);
    enable = 4'h0;
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    enable = 4'h1; load = 4'h1; set_ratio(0, 1);
    cyc(4'h1, 4'h1, 4'h1, 4'h0);
    load = 4'h0;
    cyc(4'h1, 4'h1, 4'h1, 4'h0);
    enable = 4'h0;
    cyc(4'h1, 4'h1, 4'h0, 4'h0);

    // Pending survives a disabled gap and applies at the first wrap after.
    load = 4'h1; set_ratio(0, 2);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    enable = 4'h1; set_ratio(0, 4);
    cyc(4'h1, 4'h0, 4'h1, 4'h1);
    load = 4'h0; enable = 4'h0;
    cyc(4'h1, 4'h0, 4'h0, 4'h1);
    cyc(4'h1, 4'h0, 4'h0, 4'h1);
    enable = 4'h1;
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h1, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);

    // Ratios 5 (ch0) and 6 (ch1) drift apart, then sync.
    enable = 4'h0; load = 4'b0011; set_ratio(0, 5); set_ratio(1, 6);
    cyc(4'h3, 4'h0, 4'h0, 4'h0);
    load = 4'h0; enable = 4'b0011;
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    cyc(4'h3, 4'b00, 4'b00, 4'h0);
    cyc(4'h3, 4'b00, 4'b01, 4'h0);
    cyc(4'h3, 4'b01, 4'b10, 4'h0);
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    sync = 1'b1;
`ifdef CLK_DIV_SYNC_EN
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    sync = 1'b0;
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
    cyc(4'h3, 4'b00, 4'b00, 4'h0);
    cyc(4'h3, 4'b00, 4'b01, 4'h0);
    cyc(4'h3, 4'b01, 4'b10, 4'h0);
    for (int i = 0; i < 23; i++) cyc(4'h0, 4'h0, 4'h0, 4'h0);
    cyc(4'h3, 4'b00, 4'b11, 4'h0);
    cyc(4'h3, 4'b11, 4'b00, 4'h0);
`else
    cyc(4'h3, 4'b10, 4'b00, 4'h0);
    sync = 1'b0;
    cyc(4'h3, 4'b00, 4'b01, 4'h0);
`endif

    // Reset mid-period with a pending ratio discards it; DEF_RATIO resumes.
    enable = 4'h0; load = 4'h1; set_ratio(0, 4);
    cyc(4'h1, 4'h0, 4'h0, 4'h0);
    load = 4'h0; enable = 4'h1;
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    load = 4'h1; set_ratio(0, 7);
    cyc(4'h1, 4'h0, 4'h0, 4'h1);
    load = 4'h0; rst = 1'b1;
    cyc(4'hF, 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    cyc(4'h1, 4'h0, 4'h1, 4'h0);
    cyc(4'h1, 4'h1, 4'h0, 4'h0);
    cyc(4'h1, 4'h0, 4'h1, 4'h0);

    @(negedge clk_in);
    @(negedge clk_in);
    check("queue_drained", step_no, 4'(exp_q.size()), 4'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
